// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default queue depth,
// the NOP word used for faulted fetches, and the queue entry layout.
package fetch_pkg;

   localparam int unsigned FETCH_DEPTH_DEFAULT = 4;
   localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      logic        filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: circular storage with head/tail pointers, occupancy
// count, lookup of the oldest unfilled entry, and flush invalidation.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_flush,
   input  logic          i_alloc,
   input  fetch_entry_t  i_alloc_entry,
   input  logic          i_fill,
   input  logic [31:0]   i_fill_data,
   input  logic          i_pop,
   output fetch_entry_t  o_head,
   output logic          o_head_valid,
   output logic          o_full,
   output logic [CW-1:0] o_unfilled_cnt
);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [PW-1:0] w_fill_idx;
   logic [PW-1:0] w_idx;
   logic [CW-1:0] w_unfilled_cnt;
   logic          w_fill_found;

   // Walk occupied slots from the head: the first unfilled one receives the
   // next in-order response, and the total tells the flush logic how many
   // responses are still owed by memory.
   // NOTE: blocking assignments here are intentional; each iteration must see
   // the values left by the previous one.
   always_comb begin
      w_fill_idx     = r_head;
      w_idx          = r_head;
      w_unfilled_cnt = '0;
      w_fill_found   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if ((CW'(i) < r_count) && !r_mem[w_idx].filled) begin
            if (!w_fill_found) begin
               w_fill_idx   = w_idx;
               w_fill_found = 1'b1;
            end
            w_unfilled_cnt = w_unfilled_cnt + CW'(1);
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         // NOTE: storage is reset too, so the id_* outputs read zero right
         // after reset instead of showing whatever the slots last held.
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i].filled <= 1'b0;
         end
      end else begin
         if (i_alloc) begin
            r_mem[r_tail] <= i_alloc_entry;
            r_tail        <= r_tail + PW'(1);
         end
         if (i_fill) begin
            r_mem[w_fill_idx].instr  <= i_fill_data;
            r_mem[w_fill_idx].filled <= 1'b1;
         end
         // Freed slots drop their filled bit so the head flag alone means valid.
         if (i_pop) begin
            r_mem[r_head].filled <= 1'b0;
            r_head               <= r_head + PW'(1);
         end
         case ({i_alloc, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head         = r_mem[r_head];
   assign o_head_valid   = r_mem[r_head].filled;
   assign o_full         = (r_count == CW'(DEPTH));
   assign o_unfilled_cnt = w_unfilled_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC requests to instruction memory, queues
// responses in order and hands them to decode. Optional misaligned-PC fault
// insertion is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
   parameter logic [31:0] NOP   = NOP_INSTR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   output logic        pc_advance_o,
   input  logic        flush_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o,
   output logic        id_fault_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] r_drop_cnt;

   fetch_entry_t  w_alloc_entry;
   fetch_entry_t  w_head;
   logic          w_head_valid;
   logic          w_full;
   logic [CW-1:0] w_unfilled_cnt;
   logic          w_misaligned;
   logic          w_can_alloc;
   logic          w_grant;
   logic          w_mis_alloc;
   logic          w_alloc;
   logic          w_fill;
   logic          w_rsp_counted;
   logic          w_stray_rsp;
   logic          w_pop;

`ifdef FETCH_MISALIGN_CHK_EN
   assign w_misaligned = (pc_i[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   // A slot is free and no discarded responses are still owed by memory.
   assign w_can_alloc  = ~rst_i & ~flush_i & ~w_full & (r_drop_cnt == '0);
   assign imem_req_o   = w_can_alloc & ~w_misaligned;
   assign imem_addr_o  = {pc_i[31:2], 2'b00};
   assign w_grant      = imem_req_o & imem_gnt_i;
   assign w_mis_alloc  = w_can_alloc & w_misaligned;
   assign w_alloc      = w_grant | w_mis_alloc;
   assign pc_advance_o = w_alloc;

   always_comb begin
      w_alloc_entry    = '0;
      w_alloc_entry.pc = pc_i;
      if (w_mis_alloc) begin
         w_alloc_entry.instr  = NOP;
         w_alloc_entry.fault  = 1'b1;
         w_alloc_entry.filled = 1'b1;
      end
   end

   // Responses are in order: while drop_cnt is non-zero they belong to
   // fetches that a flush already discarded.
   assign w_fill        = imem_rvalid_i & (r_drop_cnt == '0) & (w_unfilled_cnt != '0);
   assign w_rsp_counted = imem_rvalid_i & ((r_drop_cnt != '0) | (w_unfilled_cnt != '0));
   assign w_stray_rsp   = imem_rvalid_i & (r_drop_cnt == '0) & (w_unfilled_cnt == '0);

   assign id_valid_o = w_head_valid & ~flush_i;
   assign w_pop      = id_valid_o & id_ready_i;
   assign id_pc_o    = w_head.pc;
   assign id_instr_o = w_head.instr;

`ifdef FETCH_MISALIGN_CHK_EN
   assign id_fault_o = w_head.fault;
`else
   logic w_unused_fault;
   assign w_unused_fault = w_head.fault;
   assign id_fault_o     = 1'b0;
`endif

   // On flush, every unfilled entry becomes a response to discard, less the
   // one that may be arriving in the flush cycle itself.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_drop_cnt <= '0;
      end else if (flush_i) begin
         r_drop_cnt <= r_drop_cnt + w_unfilled_cnt - CW'(w_rsp_counted);
      end else if (w_rsp_counted && (r_drop_cnt != '0)) begin
         r_drop_cnt <= r_drop_cnt - CW'(1);
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk          (clk_i),
      .i_rst          (rst_i),
      .i_flush        (flush_i),
      .i_alloc        (w_alloc),
      .i_alloc_entry  (w_alloc_entry),
      .i_fill         (w_fill),
      .i_fill_data    (imem_rdata_i),
      .i_pop          (w_pop),
      .o_head         (w_head),
      .o_head_valid   (w_head_valid),
      .o_full         (w_full),
      .o_unfilled_cnt (w_unfilled_cnt)
   );

`ifndef SYNTHESIS
   // A response with nothing outstanding is a memory-side protocol error.
   a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (rst_i) !w_stray_rsp);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// checked by a scoreboard fed from an abstract queue/memory model.
module tb_fetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_i;
   logic        pc_advance_o;
   logic        flush_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_instr_o;
   logic        id_fault_o;

   always #5 clk_i = ~clk_i;

   fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .pc_i          (pc_i),
      .pc_advance_o  (pc_advance_o),
      .flush_i       (flush_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_pc_o       (id_pc_o),
      .id_instr_o    (id_instr_o),
      .id_fault_o    (id_fault_o)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      int          exp_cyc;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      int          due;
      bit          stale;
   } rsp_t;

   exp_t sb[$];     // entries the fetch stage holds, oldest first
   rsp_t pend[$];   // responses the memory still owes, in order
   int   stale_cnt;
   int   cyc;
   int   n_checks;
   int   n_fail;
   bit   timed;
   int   lat_max;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0E};
   endfunction

   function automatic bit misaligned(input logic [31:0] pc);
`ifdef FETCH_MISALIGN_CHK_EN
      return pc[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle of stimulus; the model predicts the request side and
   // records what decode must eventually receive.
   task automatic cycle(input logic [31:0] pc, input logic fl, input logic rdy,
                        input logic gnt, input logic rv_en);
      int   stale0;
      bit   exp_req;
      bit   exp_mis;
      exp_t e;
      rsp_t r;
      @(negedge clk_i);
      cyc++;
      stale0        = stale_cnt;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom();
      if (rv_en && pend.size() != 0 && pend[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = pend[0].data;
         if (pend[0].stale) stale_cnt--;
         void'(pend.pop_front());
      end
      pc_i       = pc;
      flush_i    = fl;
      id_ready_i = rdy;
      imem_gnt_i = gnt;
      #1;
      exp_req = !fl && (sb.size() < DEPTH) && (stale0 == 0) && !misaligned(pc);
      exp_mis = !fl && (sb.size() < DEPTH) && (stale0 == 0) && misaligned(pc);
      check("imem_req", 32'(imem_req_o), 32'(exp_req));
      check("pc_advance", 32'(pc_advance_o), 32'((exp_req && gnt) || exp_mis));
      if (exp_req) check("imem_addr", imem_addr_o, {pc[31:2], 2'b00});
      if (exp_req && gnt) begin
         e.pc = pc; e.instr = mem_word({pc[31:2], 2'b00}); e.fault = 1'b0;
         e.exp_cyc = timed ? cyc + 2 : -1;
         sb.push_back(e);
         r.data = e.instr; r.due = cyc + 1 + $urandom_range(0, lat_max); r.stale = 1'b0;
         pend.push_back(r);
      end
      if (exp_mis) begin
         e.pc = pc; e.instr = NOP_W; e.fault = 1'b1; e.exp_cyc = -1;
         sb.push_back(e);
      end
      if (fl) begin
         sb.delete();
         foreach (pend[i]) begin
            pend[i].stale = 1'b1;
            pend[i].data  = 32'hDEAD_0000 + 32'(i);
         end
         stale_cnt = pend.size();
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) cycle(32'h0, 1'b0, rdy, 1'b0, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_id_valid"}, 32'(id_valid_o), 32'd0);
      check({tag, "_id_pc"}, id_pc_o, 32'd0);
      check({tag, "_id_instr"}, id_instr_o, 32'd0);
      check({tag, "_id_fault"}, 32'(id_fault_o), 32'd0);
      check({tag, "_imem_req"}, 32'(imem_req_o), 32'd0);
      check({tag, "_pc_advance"}, 32'(pc_advance_o), 32'd0);
   endtask

   // Reset of the block together with the memory side: nothing is owed.
   task automatic do_reset(input string tag);
      @(negedge clk_i);
      rst_i = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      sb.delete(); pend.delete(); stale_cnt = 0;
      @(posedge clk_i);
      #1;
      check_outputs_zero(tag);
      check({tag, "_drop_cnt"}, 32'(dut.r_drop_cnt), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Monitor: every accepted decode handshake must match the oldest expected entry.
   always @(negedge clk_i) begin
      exp_t e;
      #3;
      if (!rst_i && id_valid_o && id_ready_i) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL id_unexpected: got pc 0x%08h with nothing expected (cycle %0d)", id_pc_o, cyc);
         end else begin
            e = sb.pop_front();
            check("id_pc", id_pc_o, e.pc);
            check("id_instr", id_instr_o, e.instr);
            check("id_fault", 32'(id_fault_o), 32'(e.fault));
            if (e.exp_cyc >= 0) check("id_latency", 32'(cyc), 32'(e.exp_cyc));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      n_checks = 0; n_fail = 0; cyc = 0; stale_cnt = 0; timed = 1'b0; lat_max = 0;
      rst_i = 1'b1; pc_i = '0; flush_i = 1'b0; imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_outputs_zero("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Back-to-back fetch with single-cycle memory.
      timed = 1'b1;
      cycle(32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(32'h4, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(32'h8, 1'b0, 1'b1, 1'b1, 1'b1);
      timed = 1'b0;
      idle(4, 1'b1);

      // Backpressure until the queue is full, then drain.
      for (int i = 0; i < 6; i++) cycle(32'h20 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 1'b1);
      check("bp_req_blocked", 32'(imem_req_o), 32'd0);
      check("bp_adv_blocked", 32'(pc_advance_o), 32'd0);
      check("bp_occupancy", 32'(dut.u_queue.r_count), 32'(DEPTH));
      idle(8, 1'b1);

      // Flush with two fetches in flight.
      cycle(32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
      check("flush_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
      check("flush_rsp0_data", imem_rdata_i, 32'hDEAD_0000);
      check("flush_no_valid0", 32'(id_valid_o), 32'd0);
      cycle(32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
      check("flush_rsp1_data", imem_rdata_i, 32'hDEAD_0001);
      check("flush_no_valid1", 32'(id_valid_o), 32'd0);
      cycle(32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
      check("resume_req", 32'(imem_req_o), 32'd1);
      check("resume_addr", imem_addr_o, 32'h100);
      idle(4, 1'b1);

      // Flush coinciding with a response, three fetches unfilled.
      cycle(32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(32'h204, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(32'h208, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(32'h300, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk_i);
      #1;
      check("flush_rv_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
      idle(5, 1'b1);

      // Reset with a full queue.
      for (int i = 0; i < 5; i++) cycle(32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b1, 1'b1);
      do_reset("midrst");

      // Misaligned PC.
`ifdef FETCH_MISALIGN_CHK_EN
      cycle(32'h6, 1'b0, 1'b0, 1'b1, 1'b1);
      check("mis_no_req", 32'(imem_req_o), 32'd0);
      check("mis_adv", 32'(pc_advance_o), 32'd1);
      cycle(32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
      check("mis_valid", 32'(id_valid_o), 32'd1);
      check("mis_instr", id_instr_o, NOP_W);
      check("mis_fault", 32'(id_fault_o), 32'd1);
`else
      cycle(32'h6, 1'b0, 1'b0, 1'b1, 1'b1);
      check("nochk_req", 32'(imem_req_o), 32'd1);
      check("nochk_addr", imem_addr_o, 32'h4);
      cycle(32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
      check("nochk_valid", 32'(id_valid_o), 32'd1);
      check("nochk_fault", 32'(id_fault_o), 32'd0);
`endif
      idle(4, 1'b1);

      // Random traffic with variable memory latency.
      lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc;
         pc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 999) == 0) do_reset("rndrst");
         cycle(pc, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      k = 0;
      while (k < 300 && (sb.size() != 0 || pend.size() != 0)) begin
         cycle(32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
         k++;
      end
      check("drain_sb_empty", 32'(sb.size()), 32'd0);
      check("drain_pend_empty", 32'(pend.size()), 32'd0);
      idle(1, 1'b1);
      check("drain_id_valid", 32'(id_valid_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the PC register. Takes the current PC, issues word requests to instruction memory over a grant/valid handshake, and holds returned instructions with their PCs in an in-order queue. Presents fetched instructions to decode through a valid/ready handshake. Generates the advance enable that lets next-PC logic step the PC, and discards in-flight fetches on a redirect flush.

## Interface
- DEPTH, 4: queue entries, which is also the max outstanding requests; power of two, ≥2.
- NOP, 32'h00000013: instruction word inserted for faulted fetches.
- clk_i  in  1  clock, all logic on posedge.
- rst_i  in  1  reset; synchronous, active-high.
- pc_i  in  32  current PC from the PC register.
- pc_advance_o  out  1  PC consumed this cycle; next-PC logic steps only when high.
- flush_i  in  1  redirect; drop all queued and in-flight fetches.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  request address, {pc_i[31:2],2'b00}.
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  response valid; in order, ≥1 cycle after grant.
- imem_rdata_i  in  32  response instruction.
- id_valid_o  out  1  head entry valid to decode.
- id_ready_i  in  1  decode accepts.
- id_pc_o  out  32  PC of head entry.
- id_instr_o  out  32  instruction of head entry.
- id_fault_o  out  1  head entry is a misaligned-fetch fault.

## Operation
- Queue: DEPTH entries {pc, instr, fault, filled}, circular head/tail pointers plus an occupancy counter.
- Request rule, combinational: imem_req_o = ~rst_i & ~flush_i & (occupancy < DEPTH) & (drop_cnt == 0).
- Grant (req & gnt): allocate the tail entry with pc = pc_i and filled = 0. pc_advance_o = req & gnt.
- Response: rvalid with drop_cnt == 0 writes rdata into the oldest unfilled entry and sets filled.
- Pop: id_valid_o = head filled & ~flush_i. id_valid & id_ready frees the head.
- Allocation and pop in the same cycle are legal, and occupancy is unchanged. Pop of the last entry with simultaneous alloc is legal.
- Flush: all entries invalidated at the clock edge.
  - drop_cnt ← drop_cnt + (allocated unfilled entries) − (rvalid this cycle).
  - Each later rvalid while drop_cnt > 0 is discarded and decrements drop_cnt.
  - No request is issued in the flush cycle or while drop_cnt ≠ 0.
  - A handshake on id in the flush cycle does not count.
- rvalid with no unfilled entry and drop_cnt == 0 is a protocol error. It is ignored, and an assertion fires in simulation.
- drop_cnt width is clog2(DEPTH)+1 and it never underflows.

## Timing
- Reset values: id_valid_o=0, id_pc_o=0, id_instr_o=0, id_fault_o=0, imem_req_o=0, pc_advance_o=0, occupancy=0, drop_cnt=0, pointers=0.
- Reset mid-operation clears everything in one edge. Responses arriving afterwards count as stray, and the memory side must be reset together with this block.
- Latency: grant in cycle G, response in R ≥ G+1, id_valid_o high in R+1.
- Throughput: 1 instr/cycle sustained with 1-cycle memory, DEPTH ≥ 3, and id_ready_i held high.
- Outputs id_* are driven from registered queue state, with no combinational path from imem_rdata_i.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - pc_i[1:0] ≠ 0 issues no memory request.
  - When occupancy < DEPTH and drop_cnt == 0, an entry is allocated already filled, with instr=NOP and fault=1.
  - pc_advance_o pulses in that cycle.
- FETCH_MISALIGN_CHK_EN undefined: pc_i[1:0] is ignored and id_fault_o is tied to 0.

## Structure
- Package fetch_pkg holds:
  - the NOP constant;
  - the queue-entry struct typedef {pc, instr, fault, filled};
  - the DEPTH default.
- One sub-module, fetch_queue, holds storage, pointers, occupancy, fill pointer and flush clear. fetch_unit holds the request logic and drop_cnt.

## Test plan
- Back-to-back fetch: 1-cycle memory, pc 0x0,0x4,0x8 granted on consecutive cycles, id_ready_i=1 → id_pc_o 0x0,0x4,0x8 on consecutive cycles, each starting 2 cycles after its grant.
- Backpressure: id_ready_i=0 with 4 grants → occupancy 4, imem_req_o=0, pc_advance_o=0. Raise ready → drains in order.
- Flush with 2 in flight: flush_i with two unfilled entries → drop_cnt=2. Next two rvalid (0xDEAD0000, 0xDEAD0001) discarded, id_valid_o stays 0. Request resumes at the new pc_i 0x100.
- Flush and rvalid in the same cycle with 3 unfilled → drop_cnt=2.
- Reset mid-run: rst_i high one cycle with a full queue → every output 0 the next cycle.
- Misalign (macro on): pc_i=0x6 → no imem_req_o, then id_instr_o=32'h00000013 with id_fault_o=1. Macro off: imem_addr_o=0x4, id_fault_o=0.
